// File: rtl/frame_detector_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frame_detector_pkg                                         |
// | Description : Shared constants, receiver state encoding and helper       |
// |               functions (Gray encoding, word-wide CRC-16-CCITT step)     |
// |               for the framed-stream receiver.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package frame_detector_pkg;

    localparam logic [15:0] HDR_WORD  = 16'hE0E0;
    localparam logic [15:0] TRL_WORD  = 16'h0E0E;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'h0000;
    localparam int          MAX_WORDS = 8;

    // Receiver state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_HUNT  = 2'd0;
    localparam state_t ST_HDR   = 2'd1;
    localparam state_t ST_BODY  = 2'd2;
    localparam state_t ST_CHECK = 2'd3;

    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    // One 16-bit word through the CRC register, MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                               input logic [15:0] w);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ w[i]) begin
                c = (c << 1) ^ CRC_POLY;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frame_serializer                                           |
// | Description : Single-frame output buffer. Captures a payload on i_load   |
// |               when idle, then shifts every word out Gray-coded, MSB     |
// |               first, on every channel selected by the mask.             |
// | Ports       : clk, rst_n          clock / async active-low reset         |
// |               i_load              store request (ignored while busy)     |
// |               i_words/i_count     payload words and number of words      |
// |               i_mask              one bit per output channel             |
// |               o_dout/o_vld        registered per-channel bit and valid   |
// |               o_full/o_empty      registered buffer occupancy            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module frame_serializer
    import frame_detector_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_load,
    input  logic [MAX_WORDS-1:0][15:0]  i_words,
    input  logic [3:0]                  i_count,
    input  logic [7:0]                  i_mask,
    output logic [7:0]                  o_dout,
    output logic [7:0]                  o_vld,
    output logic                        o_full,
    output logic                        o_empty
);

    logic [MAX_WORDS-1:0][15:0] r_gray;
    logic [3:0]                 r_count;
    logic [7:0]                 r_mask;
    logic [2:0]                 r_widx;
    logic [3:0]                 r_bidx;
    logic                       r_full;
    logic                       r_empty;
    logic [7:0]                 r_dout;
    logic [7:0]                 r_vld;

    logic [MAX_WORDS-1:0][15:0] w_gray_n;
    logic [3:0]                 w_count_n;
    logic [7:0]                 w_mask_n;
    logic [2:0]                 w_widx_n;
    logic [3:0]                 w_bidx_n;
    logic                       w_full_n;
    logic [15:0]                w_cur;
    logic                       w_bit;
    logic [7:0]                 w_vld_n;
    logic [7:0]                 w_dout_n;

    always_comb begin
        w_gray_n  = r_gray;
        w_count_n = r_count;
        w_mask_n  = r_mask;
        w_widx_n  = r_widx;
        w_bidx_n  = r_bidx;
        w_full_n  = r_full;
        if (r_full) begin
            // A load arriving while busy is dropped here by design.
            if (r_bidx == 4'd15) begin
                w_bidx_n = 4'd0;
                if ({1'b0, r_widx} == (r_count - 4'd1)) begin
                    w_full_n = 1'b0;
                end else begin
                    w_widx_n = r_widx + 3'd1;
                end
            end else begin
                w_bidx_n = r_bidx + 4'd1;
            end
        end else if (i_load) begin
            w_full_n  = 1'b1;
            w_widx_n  = 3'd0;
            w_bidx_n  = 4'd0;
            w_count_n = i_count;
            w_mask_n  = i_mask;
            for (int i = 0; i < MAX_WORDS; i++) begin
                w_gray_n[i] = bin2gray(i_words[i]);
            end
        end
        // Outputs are computed from the next position so they leave flops.
        w_cur    = w_gray_n[w_widx_n];
        w_bit    = w_cur[4'd15 - w_bidx_n];
        w_vld_n  = w_full_n ? w_mask_n : 8'h00;
        w_dout_n = w_bit ? w_vld_n : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray  <= '0;
            r_count <= 4'd0;
            r_mask  <= 8'h00;
            r_widx  <= 3'd0;
            r_bidx  <= 4'd0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_dout  <= 8'h00;
            r_vld   <= 8'h00;
        end else begin
            r_gray  <= w_gray_n;
            r_count <= w_count_n;
            r_mask  <= w_mask_n;
            r_widx  <= w_widx_n;
            r_bidx  <= w_bidx_n;
            r_full  <= w_full_n;
            r_empty <= ~w_full_n;
            r_dout  <= w_dout_n;
            r_vld   <= w_vld_n;
        end
    end

    assign o_dout  = r_dout;
    assign o_vld   = r_vld;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/frame_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frame_detector                                             |
// | Description : Hunts a 16-bit stream for E0E0 E0E0 headers, captures the  |
// |               channel mask and 1..8 payload words, verifies the          |
// |               CRC-16-CCITT word and hands good frames to the serializer. |
// | Ports       : clk_in, rst_n       clock / async active-low reset         |
// |               data_in             stream word, one per cycle             |
// |               data_out_chN        serial payload bit, channel N          |
// |               data_vld_chN        valid for data_out_chN                 |
// |               fifo_empty/full     output buffer occupancy                |
// |               crc_valid/crc_err   one-cycle frame result pulses          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module frame_detector
    import frame_detector_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    output logic        data_out_ch1,
    output logic        data_out_ch2,
    output logic        data_out_ch3,
    output logic        data_out_ch4,
    output logic        data_out_ch5,
    output logic        data_out_ch6,
    output logic        data_out_ch7,
    output logic        data_out_ch8,
    output logic        data_vld_ch1,
    output logic        data_vld_ch2,
    output logic        data_vld_ch3,
    output logic        data_vld_ch4,
    output logic        data_vld_ch5,
    output logic        data_vld_ch6,
    output logic        data_vld_ch7,
    output logic        data_vld_ch8,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        crc_valid,
    output logic        crc_err
);

    // Body words received before an unterminated body is abandoned.
    localparam logic [3:0] c_BODY_CAP = 4'd10;

    state_t                     r_state,     w_state_n;
    logic                       r_prev_hdr,  w_prev_hdr_n;
    logic [7:0]                 r_mask,      w_mask_n;
    logic [MAX_WORDS-1:0][15:0] r_body,      w_body_n;
    logic [3:0]                 r_cnt,       w_cnt_n;
    logic [15:0]                r_crc,       w_crc_n;
    logic [15:0]                r_crc_prev,  w_crc_prev_n;
    logic                       r_last_trl,  w_last_trl_n;
    logic [3:0]                 r_plen,      w_plen_n;
    logic                       r_crc_valid, w_crc_valid_n;
    logic                       r_crc_err,   w_crc_err_n;

    logic w_is_hdr;
    logic w_is_trl;
    logic [7:0] w_ser_dout;
    logic [7:0] w_ser_vld;

    assign w_is_hdr = (data_in == HDR_WORD);
    assign w_is_trl = (data_in == TRL_WORD);

    always_comb begin
        w_state_n     = r_state;
        w_prev_hdr_n  = r_prev_hdr;
        w_mask_n      = r_mask;
        w_body_n      = r_body;
        w_cnt_n       = r_cnt;
        w_crc_n       = r_crc;
        w_crc_prev_n  = r_crc_prev;
        w_last_trl_n  = r_last_trl;
        w_plen_n      = r_plen;
        w_crc_valid_n = 1'b0;
        w_crc_err_n   = 1'b0;
        case (r_state)
            // CHECK only exists to present the result pulse; the stream
            // keeps being hunted so a new frame may start immediately.
            ST_HUNT, ST_CHECK: begin
                w_state_n = ST_HUNT;
                if (w_is_hdr && r_prev_hdr) begin
                    w_state_n    = ST_HDR;
                    w_prev_hdr_n = 1'b0;
                end else begin
                    w_prev_hdr_n = w_is_hdr;
                end
            end
            ST_HDR: begin
                if (!w_is_hdr) begin
                    if (data_in[7:0] == 8'h00) begin
                        w_state_n = ST_HUNT;
                    end else begin
                        w_state_n    = ST_BODY;
                        w_mask_n     = data_in[7:0];
                        w_cnt_n      = 4'd0;
                        w_crc_n      = CRC_INIT;
                        w_crc_prev_n = CRC_INIT;
                        w_last_trl_n = 1'b0;
                    end
                end
            end
            ST_BODY: begin
                if (w_is_trl && r_last_trl) begin
                    // r_cnt counts payload + CRC + first trailer.
                    w_prev_hdr_n = 1'b0;
                    if (r_cnt >= 4'd3 && r_cnt <= c_BODY_CAP) begin
                        w_state_n = ST_CHECK;
                        w_plen_n  = r_cnt - 4'd2;
                        // r_crc_prev has run over payload and CRC word;
                        // with zero init and no final XOR a match leaves 0.
                        if (r_crc_prev == 16'h0000) begin
                            w_crc_valid_n = 1'b1;
                        end else begin
                            w_crc_err_n = 1'b1;
                        end
                    end else begin
                        w_state_n = ST_HUNT;
                    end
                end else if (r_cnt == c_BODY_CAP) begin
                    // Body already too long to be legal: drop the frame.
                    w_state_n    = ST_HUNT;
                    w_prev_hdr_n = w_is_hdr;
                end else begin
                    // The CRC word and trailers are never replayed, so only
                    // payload positions are kept.
                    if (r_cnt < 4'(MAX_WORDS)) begin
                        w_body_n[r_cnt[2:0]] = data_in;
                    end
                    w_cnt_n      = r_cnt + 4'd1;
                    w_crc_prev_n = r_crc;
                    w_crc_n      = crc16_word(r_crc, data_in);
                    w_last_trl_n = w_is_trl;
                end
            end
            default: w_state_n = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_prev_hdr  <= 1'b0;
            r_mask      <= 8'h00;
            r_body      <= '0;
            r_cnt       <= 4'd0;
            r_crc       <= CRC_INIT;
            r_crc_prev  <= CRC_INIT;
            r_last_trl  <= 1'b0;
            r_plen      <= 4'd0;
            r_crc_valid <= 1'b0;
            r_crc_err   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_prev_hdr  <= w_prev_hdr_n;
            r_mask      <= w_mask_n;
            r_body      <= w_body_n;
            r_cnt       <= w_cnt_n;
            r_crc       <= w_crc_n;
            r_crc_prev  <= w_crc_prev_n;
            r_last_trl  <= w_last_trl_n;
            r_plen      <= w_plen_n;
            r_crc_valid <= w_crc_valid_n;
            r_crc_err   <= w_crc_err_n;
        end
    end

    // The payload stays untouched in r_body through CHECK, so the load
    // can follow the crc_valid pulse by one cycle.
    frame_serializer u_ser (
        .clk     (clk_in),
        .rst_n   (rst_n),
        .i_load  (r_crc_valid),
        .i_words (r_body),
        .i_count (r_plen),
        .i_mask  (r_mask),
        .o_dout  (w_ser_dout),
        .o_vld   (w_ser_vld),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign crc_valid    = r_crc_valid;
    assign crc_err      = r_crc_err;
    assign data_out_ch1 = w_ser_dout[0];
    assign data_out_ch2 = w_ser_dout[1];
    assign data_out_ch3 = w_ser_dout[2];
    assign data_out_ch4 = w_ser_dout[3];
    assign data_out_ch5 = w_ser_dout[4];
    assign data_out_ch6 = w_ser_dout[5];
    assign data_out_ch7 = w_ser_dout[6];
    assign data_out_ch8 = w_ser_dout[7];
    assign data_vld_ch1 = w_ser_vld[0];
    assign data_vld_ch2 = w_ser_vld[1];
    assign data_vld_ch3 = w_ser_vld[2];
    assign data_vld_ch4 = w_ser_vld[3];
    assign data_vld_ch5 = w_ser_vld[4];
    assign data_vld_ch6 = w_ser_vld[5];
    assign data_vld_ch7 = w_ser_vld[6];
    assign data_vld_ch8 = w_ser_vld[7];

endmodule
`default_nettype wire

// File: tb/tb_frame_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_frame_detector                                          |
// | Description : Self-checking bench for frame_detector. A word-level frame |
// |               model predicts, per clock, the result pulses, buffer       |
// |               occupancy and every serial bit on all eight channels.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_frame_detector;

    localparam int          NC  = 16384;
    localparam logic [15:0] HDR = 16'hE0E0;
    localparam logic [15:0] TRL = 16'h0E0E;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [7:0]  dout;
    logic [7:0]  vld;
    logic        fifo_empty, fifo_full, crc_valid, crc_err;

    always #5 clk_in = ~clk_in;

    frame_detector u_dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_out_ch1 (dout[0]), .data_out_ch2 (dout[1]),
        .data_out_ch3 (dout[2]), .data_out_ch4 (dout[3]),
        .data_out_ch5 (dout[4]), .data_out_ch6 (dout[5]),
        .data_out_ch7 (dout[6]), .data_out_ch8 (dout[7]),
        .data_vld_ch1 (vld[0]),  .data_vld_ch2 (vld[1]),
        .data_vld_ch3 (vld[2]),  .data_vld_ch4 (vld[3]),
        .data_vld_ch5 (vld[4]),  .data_vld_ch6 (vld[5]),
        .data_vld_ch7 (vld[6]),  .data_vld_ch8 (vld[7]),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .crc_valid    (crc_valid),
        .crc_err      (crc_err)
    );

    // Expected outputs, indexed by the clock edge after which they hold.
    bit [7:0] exp_msk [NC];
    bit       exp_bit [NC];
    bit       exp_v   [NC];
    bit       exp_e   [NC];
    bit       exp_f   [NC];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Frame model state
    int          m_state    = 0;   // 0 hunting, 1 after header, 2 in body
    bit          m_prev_hdr = 1'b0;
    bit [7:0]    m_mask     = 8'h00;
    logic [15:0] m_body [$];
    int          busy_until = 0;

    // Capture of one DUT channel for directed checks
    int          cap_sel   = 0;
    logic [15:0] cap_word  = 16'h0000;
    logic [15:0] cap_first = 16'h0000;
    int          cap_len   = 0;

    logic [15:0] pq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] w [$]);
        logic [15:0] r;
        bit fb;
        r = 16'h0000;
        foreach (w[i]) begin
            for (int b = 15; b >= 0; b--) begin
                fb = r[15] ^ w[i][b];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    task automatic model_word(input logic [15:0] w);
        int          n;
        int          plen;
        int          idx;
        logic [15:0] pl [$];
        logic [15:0] g;
        case (m_state)
            0: begin
                if (w == HDR && m_prev_hdr) begin
                    m_state = 1; m_prev_hdr = 1'b0;
                end else begin
                    m_prev_hdr = (w == HDR);
                end
            end
            1: begin
                if (w != HDR) begin
                    if (w[7:0] == 8'h00) begin
                        m_state = 0;
                    end else begin
                        m_mask = w[7:0];
                        m_body.delete();
                        m_state = 2;
                    end
                end
            end
            default: begin
                m_body.push_back(w);
                n = m_body.size();
                if (n >= 2 && m_body[n-1] == TRL && m_body[n-2] == TRL) begin
                    m_state = 0; m_prev_hdr = 1'b0;
                    plen = n - 3;
                    if (plen >= 1 && plen <= 8) begin
                        pl.delete();
                        for (int i = 0; i < plen; i++) pl.push_back(m_body[i]);
                        if (ref_crc(pl) == m_body[plen]) begin
                            exp_v[cyc] = 1'b1;
                            if (busy_until <= cyc) begin
                                for (int i = 0; i < plen; i++) begin
                                    g = pl[i] ^ (pl[i] >> 1);
                                    for (int b = 0; b < 16; b++) begin
                                        idx = cyc + 1 + 16 * i + b;
                                        if (idx < NC) begin
                                            exp_msk[idx] = m_mask;
                                            exp_bit[idx] = g[15-b];
                                            exp_f[idx]   = 1'b1;
                                        end
                                    end
                                end
                                busy_until = cyc + 1 + 16 * plen;
                            end
                        end else begin
                            exp_e[cyc] = 1'b1;
                        end
                    end
                end else if (n == 11) begin
                    m_state = 0; m_prev_hdr = (w == HDR);
                end
            end
        endcase
    endtask

    task automatic check_cycle();
        if (cyc < NC) begin
            chk("vld",  {24'h0, vld}, {24'h0, exp_msk[cyc]});
            chk("dout", {24'h0, dout}, {24'h0, (exp_bit[cyc] ? exp_msk[cyc] : 8'h00)});
            chk("flags", {28'h0, crc_valid, crc_err, fifo_full, fifo_empty},
                         {28'h0, exp_v[cyc], exp_e[cyc], exp_f[cyc], ~exp_f[cyc]});
        end else begin
            chk("budget", cyc, NC - 1);
        end
        if (vld[cap_sel]) begin
            cap_word = {cap_word[14:0], dout[cap_sel]};
            cap_len++;
            if (cap_len == 16) cap_first = cap_word;
        end
    endtask

    task automatic send(input logic [15:0] w);
        data_in = w;
        model_word(w);
        @(posedge clk_in);
        #1;
        check_cycle();
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) send(16'h0000);
    endtask

    // Sends the frame whose payload is in pq.
    task automatic send_frame(input int extra_hdr, input logic [15:0] chw, input bit bad);
        logic [15:0] c;
        c = ref_crc(pq);
        if (bad) c = ~c;
        send(HDR); send(HDR);
        repeat (extra_hdr) send(HDR);
        send(chw);
        foreach (pq[i]) send(pq[i]);
        send(c); send(TRL); send(TRL);
    endtask

    task automatic cap_reset(input int sel);
        cap_sel = sel; cap_word = 16'h0; cap_first = 16'h0; cap_len = 0;
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out",  {16'h0, vld, dout}, 32'h0);
        chk("rst_flag", {28'h0, crc_valid, crc_err, fifo_full, fifo_empty}, 32'h1);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NC; i++) begin
            exp_msk[i] = 8'h0; exp_bit[i] = 1'b0; exp_v[i] = 1'b0;
            exp_e[i] = 1'b0;   exp_f[i] = 1'b0;
        end
        busy_until = 0; m_state = 0; m_prev_hdr = 1'b0;
        cyc++;
    endtask

    initial begin
        int          n;
        int          r;
        logic [7:0]  mask;
        logic [15:0] w;

        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_out",  {16'h0, vld, dout}, 32'h0);
        chk("reset_flag", {28'h0, crc_valid, crc_err, fifo_full, fifo_empty}, 32'h1);
        rst_n = 1'b1;

        // Single word, good CRC, channel 1
        cap_reset(0);
        pq.delete(); pq.push_back(16'h0001);
        send_frame(0, 16'h0001, 1'b0);
        idle(24);
        chk("t1_word", {16'h0, cap_word}, 32'h0001);
        chk("t1_len", cap_len, 16);

        // Bad CRC: no output
        cap_reset(0);
        pq.delete(); pq.push_back(16'h0000);
        send_frame(0, 16'h0001, 1'b1);
        idle(6);
        chk("t2_len", cap_len, 0);

        // Eight words on channel 2, three header words
        cap_reset(1);
        pq.delete();
        pq.push_back(16'h0123); pq.push_back(16'h4567); pq.push_back(16'h89AB); pq.push_back(16'hCDEF);
        pq.push_back(16'hFEDC); pq.push_back(16'hBA98); pq.push_back(16'h7654); pq.push_back(16'h3210);
        send_frame(1, 16'h0002, 1'b0);
        idle(140);
        chk("t3_first", {16'h0, cap_first}, 32'h01B2);
        chk("t3_last",  {16'h0, cap_word},  32'h2B18);
        chk("t3_len", cap_len, 128);

        // Multi-hot mask 0x0C
        cap_reset(2);
        pq.delete(); pq.push_back(16'hA55A);
        send_frame(0, 16'h550C, 1'b0);
        idle(24);
        chk("t4_word", {16'h0, cap_word}, 32'hF7F7);
        chk("t4_len", cap_len, 16);

        // Back-to-back: the second frame meets a busy buffer
        cap_reset(0);
        pq.delete(); pq.push_back(16'h1234);
        send_frame(0, 16'h0001, 1'b0);
        send_frame(0, 16'h0001, 1'b0);
        idle(30);
        chk("t5_word", {16'h0, cap_word}, 32'h1B2E);
        chk("t5_len", cap_len, 16);

        // Overlong body, zero channel byte, then a normal frame
        cap_reset(0);
        pq.delete();
        for (int i = 0; i < 9; i++) pq.push_back(16'h1111 * 16'(i + 1));
        send_frame(0, 16'h0001, 1'b0);
        pq.delete(); pq.push_back(16'h5555);
        send_frame(0, 16'hAB00, 1'b0);
        pq.delete(); pq.push_back(16'hBEEF);
        send_frame(0, 16'h0001, 1'b0);
        idle(24);
        chk("t6_word", {16'h0, cap_word}, 32'hE198);
        chk("t6_len", cap_len, 16);

        // Reset in the middle of serialization
        pq.delete();
        for (int i = 0; i < 8; i++) pq.push_back(16'($urandom));
        send_frame(0, 16'h00FF, 1'b0);
        idle(40);
        chk("t7_busy", {31'h0, fifo_full}, 32'h1);
        mid_reset();
        idle(4);

        // Randomized frames with random gaps and occasional defects
        for (int f = 0; f < 120 && cyc < NC - 600; f++) begin
            pq.delete();
            r = $urandom_range(0, 9);
            n = (r == 9) ? 9 : r;
            for (int i = 0; i < n; i++) pq.push_back(16'($urandom));
            mask = 8'($urandom);
            if (mask == 8'h00) mask = 8'h01;
            if ($urandom_range(0, 15) == 0) mask = 8'h00;
            w = {8'($urandom), mask};
            send_frame($urandom_range(0, 2), w, ($urandom_range(0, 3) == 0));
            n = $urandom_range(0, 25);
            for (int i = 0; i < n; i++) send(16'($urandom));
        end
        idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
